// File: rtl/led_blink_pkg.sv
// Shared constants and types for the LED blink MMIO core.
// Register map addresses and the default period width.
package led_blink_pkg;

  localparam int unsigned CTRL_ADDR    = 0;
  localparam int unsigned STATUS_ADDR  = 1;
  localparam int unsigned PERIOD_BASE  = 2;
  localparam int unsigned PERIOD_W_DEF = 16;

  typedef logic [PERIOD_W_DEF-1:0] period_t;

endpackage

// File: rtl/led_blink_channel.sv
// One LED channel: counts ms tics and toggles its LED
// every `period` tics while enabled.
module led_blink_channel
  import led_blink_pkg::*;
#(
  parameter int unsigned PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tic,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  input  logic                restart,
  output logic                led
);

  logic [PERIOD_W-1:0] cnt_q;
  logic                led_q;
  logic [PERIOD_W-1:0] last;

  // Underflow at period==0 is masked by the hold-off branch.
  assign last = period - PERIOD_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else if (restart) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else if (!en || period == '0) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else if (tic) begin
      if (cnt_q == last) begin
        cnt_q <= '0;
        led_q <= ~led_q;
      end else begin
        cnt_q <= cnt_q + PERIOD_W'(1);
      end
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_blink_core.sv
// MMIO slot core driving N_LED blinking outputs from a 1 ms tic.
// Holds CTRL/PERIOD registers, write decode and the read mux.
module led_blink_core
  import led_blink_pkg::*;
#(
  parameter int unsigned N_LED    = 4,
  parameter int unsigned PERIOD_W = PERIOD_W_DEF,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tic,
  input  logic              cs,
  input  logic              write,
  input  logic              read,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [N_LED-1:0]  led
);

  logic [N_LED-1:0]    ctrl_q;
  logic [N_LED-1:0]    ctrl_d;
  logic [PERIOD_W-1:0] period_q [N_LED];
  logic [PERIOD_W-1:0] period_d [N_LED];
  logic [N_LED-1:0]    restart;
  logic                wr_en;
  logic                ctrl_hit;

  // Reads have no side effects; only the upper data bits are dropped.
  logic unused_bits;
  assign unused_bits = ^{read, wr_data[DATA_W-1:PERIOD_W]};

  assign wr_en    = cs & write;
  assign ctrl_hit = wr_en && (addr == ADDR_W'(CTRL_ADDR));

  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_hit) ctrl_d = wr_data[N_LED-1:0];
  end

  always_comb begin
    for (int i = 0; i < N_LED; i++) begin
      period_d[i] = period_q[i];
      restart[i]  = ctrl_hit && (ctrl_d[i] != ctrl_q[i]);
      if (wr_en && addr == ADDR_W'(PERIOD_BASE + i)) begin
        period_d[i] = wr_data[PERIOD_W-1:0];
        restart[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      for (int i = 0; i < N_LED; i++)
        period_q[i] <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      for (int i = 0; i < N_LED; i++)
        period_q[i] <= period_d[i];
    end
  end

  for (genvar g = 0; g < N_LED; g++) begin : g_ch
    led_blink_channel #(
      .PERIOD_W (PERIOD_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .tic     (tic),
      .en      (ctrl_q[g]),
      .period  (period_q[g]),
      .restart (restart[g]),
      .led     (led[g])
    );
  end

  always_comb begin
    rd_data = '0;
    if (addr == ADDR_W'(CTRL_ADDR))
      rd_data[N_LED-1:0] = ctrl_q;
    if (addr == ADDR_W'(STATUS_ADDR))
      rd_data[N_LED-1:0] = led;
    for (int i = 0; i < N_LED; i++)
      if (addr == ADDR_W'(PERIOD_BASE + i))
        rd_data[PERIOD_W-1:0] = period_q[i];
  end

endmodule

// File: tb/tb_led_blink_core.sv
// Directed self-checking bench for led_blink_core.
// Tics are hand-driven so toggle points are exact.
module tb_led_blink_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tic = 1'b0;
  logic        cs = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic [3:0]  led;

  int n_tests = 0;
  int n_fail  = 0;

  led_blink_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tic     (tic),
    .cs      (cs),
    .write   (write),
    .read    (read),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .led     (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One clk edge with tic; returns at the following negedge.
  task automatic do_tic();
    @(negedge clk);
    tic = 1'b1;
    @(negedge clk);
    tic = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d,
                    input logic with_tic);
    @(negedge clk);
    cs = 1'b1; write = 1'b1;
    addr = a; wr_data = d;
    tic = with_tic;
    @(negedge clk);
    cs = 1'b0; write = 1'b0;
    tic = 1'b0;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [4:0] a,
                        input logic [31:0] exp);
    @(negedge clk);
    cs = 1'b1; read = 1'b1; addr = a;
    #1;
    chk(tag, rd_data, exp);
    cs = 1'b0; read = 1'b0;
  endtask

  logic [3:0] exp_led;

  initial begin
    // Reset with tic running
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tic = ~tic;
    end
    tic = 1'b0;
    chk("rst_led", 32'(led), 32'h0);
    rd_chk("rst_ctrl", 5'h00, 32'h0);
    rd_chk("rst_stat", 5'h01, 32'h0);
    rd_chk("rst_per0", 5'h02, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // PERIOD0=3: led0 toggles on tics 3,6,9,12
    wr(5'h02, 32'd3, 1'b0);
    wr(5'h00, 32'h1, 1'b0);
    rd_chk("per0_rb", 5'h02, 32'd3);
    rd_chk("ctrl_rb", 5'h00, 32'h1);
    for (int k = 1; k <= 12; k++) begin
      do_tic();
      exp_led = {3'b000, 1'(((k / 3) % 2))};
      chk($sformatf("p3_t%0d", k), 32'(led), 32'(exp_led));
    end

    // PERIOD1=1: led1 toggles every tic; ch0 disabled
    wr(5'h03, 32'd1, 1'b0);
    wr(5'h00, 32'h2, 1'b0);
    chk("p1_start", 32'(led), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      do_tic();
      exp_led = {2'b00, 1'(k % 2), 1'b0};
      chk($sformatf("p1_t%0d", k), 32'(led), 32'(exp_led));
      rd_chk($sformatf("p1_st%0d", k), 5'h01, 32'(exp_led));
    end

    // PERIOD2=0 holds led2 off
    wr(5'h04, 32'd0, 1'b0);
    wr(5'h00, 32'h4, 1'b0);
    for (int k = 1; k <= 100; k++) begin
      do_tic();
      chk($sformatf("p0_t%0d", k), 32'(led), 32'h0);
    end

    // Restart on tic 4 pushes the toggle to tic 9
    wr(5'h02, 32'd5, 1'b0);
    wr(5'h00, 32'h1, 1'b0);
    for (int k = 1; k <= 3; k++) do_tic();
    chk("rs_t3", 32'(led), 32'h0);
    wr(5'h02, 32'd5, 1'b1);
    chk("rs_t4", 32'(led), 32'h0);
    for (int k = 5; k <= 8; k++) do_tic();
    chk("rs_t8", 32'(led), 32'h0);
    do_tic();
    chk("rs_t9", 32'(led), 32'h1);

    // Same CTRL value does not restart
    wr(5'h00, 32'h1, 1'b0);
    for (int k = 10; k <= 13; k++) do_tic();
    chk("same_t13", 32'(led), 32'h1);
    do_tic();
    chk("same_t14", 32'(led), 32'h0);

    // Unmapped write ignored; upper bits masked
    wr(5'h1F, 32'hFFFF_FFFF, 1'b0);
    rd_chk("unm_rd", 5'h1F, 32'h0);
    rd_chk("unm_ctrl", 5'h00, 32'h1);
    rd_chk("unm_per0", 5'h02, 32'd5);
    wr(5'h05, 32'hABCD_1234, 1'b0);
    rd_chk("per3_mask", 5'h05, 32'h1234);
    wr(5'h00, 32'hFFFF_FFF1, 1'b0);
    rd_chk("ctrl_mask", 5'h00, 32'h1);

    // Mid-count async reset
    for (int k = 15; k <= 21; k++) do_tic();
    chk("mr_pre", 32'(led), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_led", 32'(led), 32'h0);
    cs = 1'b1; read = 1'b1; addr = 5'h00;
    #1;
    chk("mr_ctrl", rd_data, 32'h0);
    cs = 1'b0; read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("mr_per0", 5'h02, 32'h0);
    for (int k = 1; k <= 10; k++) do_tic();
    chk("mr_idle", 32'(led), 32'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
